// File: rtl/dram_burst_adapter.sv
// rtl/dram_burst_adapter.sv - 288-bit user request to two-beat DRAM burst adapter
//
// Turns single-cycle 288-bit user requests into the controller's two-beat
// burst. The command cycle carries the low 144 bits and the next cycle carries
// the high 144 bits. Two returned 144-bit read beats are reassembled into one
// 288-bit response. Reads in flight are bounded by MAX_OUTSTANDING_RD.
//
// Optional feature macro: DRAM_BURST_ADAPTER_STATS_EN (burst statistics counters)
//
// Ports:
//   dram_clk, dram_rst        clock, synchronous active-high reset
//   usr_cmd_valid/ready       user request handshake
//   usr_cmd_rnw, usr_cmd_addr request type (1=read) and burst address
//   usr_wr_data, usr_wr_be    288-bit write data / 36 byte enables ({beat1, beat0})
//   usr_rd_data, usr_rd_valid reassembled read data ({beat1, beat0}), 1-cycle strobe
//   rd_err                    sticky: read beat arrived with no read outstanding
//   dram_cmd_*                command, address and write beats to the controller
//   dram_wr_data, dram_wr_be  write beat to the controller
//   dram_rd_data/valid        read beats from the controller
//   dram_ready                controller back-pressure
//   stat_wr_cnt, stat_rd_cnt  issued write/read burst counters (0 when stats disabled)

module dram_burst_adapter #(
  parameter int MAX_OUTSTANDING_RD = 32,
  parameter int ADDR_WIDTH         = 32
) (
  input  logic                  dram_clk,
  input  logic                  dram_rst,
  input  logic                  usr_cmd_valid,
  output logic                  usr_cmd_ready,
  input  logic                  usr_cmd_rnw,
  input  logic [ADDR_WIDTH-1:0] usr_cmd_addr,
  input  logic [287:0]          usr_wr_data,
  input  logic [35:0]           usr_wr_be,
  output logic [287:0]          usr_rd_data,
  output logic                  usr_rd_valid,
  output logic                  rd_err,
  output logic [31:0]           dram_cmd_addr,
  output logic                  dram_cmd_rnw,
  output logic                  dram_cmd_valid,
  output logic [143:0]          dram_wr_data,
  output logic [17:0]           dram_wr_be,
  input  logic [143:0]          dram_rd_data,
  input  logic                  dram_rd_valid,
  input  logic                  dram_ready,
  output logic [31:0]           stat_wr_cnt,
  output logic [31:0]           stat_rd_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  localparam logic [7:0] MAX_RD = 8'(MAX_OUTSTANDING_RD);

  state_t       state;
  state_t       state_next;

  logic [7:0]   rd_outstanding;
  logic         rd_toggle;
  logic [143:0] rd_low;
  logic [143:0] wr_data_hi;
  logic [17:0]  wr_be_hi;
  logic [31:0]  addr_ext;
  logic         issue_slot;
  logic         rd_full;
  logic         accept;
  logic         rd_inc;
  logic         rd_dec;

  // A new command may only start where the previous burst's second beat
  // is on the bus (or nothing is), so bursts issue at most every 2 cycles.
  assign issue_slot    = (state == IDLE) || (state == BEAT1);
  assign rd_full       = (rd_outstanding == MAX_RD);
  assign usr_cmd_ready = issue_slot && dram_ready && !(usr_cmd_rnw && rd_full);
  assign accept        = usr_cmd_valid && usr_cmd_ready;

  always_comb begin
    addr_ext                 = '0;
    addr_ext[ADDR_WIDTH-1:0] = usr_cmd_addr;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge dram_clk) begin
    if (dram_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BEAT0;
      BEAT0:   state_next = BEAT1;
      BEAT1:   state_next = accept ? BEAT0 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------ command datapath
  // Outputs are registered alongside the state, so the values loaded here
  // appear in the cycle whose state they belong to.
  always_ff @(posedge dram_clk) begin
    if (dram_rst) begin
      dram_cmd_valid <= 1'b0;
      dram_cmd_addr  <= '0;
      dram_cmd_rnw   <= 1'b0;
      dram_wr_data   <= '0;
      dram_wr_be     <= '0;
      wr_data_hi     <= '0;
      wr_be_hi       <= '0;
    end else if (accept) begin
      dram_cmd_valid <= 1'b1;
      dram_cmd_addr  <= addr_ext;
      dram_cmd_rnw   <= usr_cmd_rnw;
      dram_wr_data   <= usr_wr_data[143:0];
      dram_wr_be     <= usr_wr_be[17:0];
      wr_data_hi     <= usr_wr_data[287:144];
      wr_be_hi       <= usr_wr_be[35:18];
    end else if (state == BEAT0) begin
      // Second beat: address and rnw stay on the bus unchanged.
      dram_cmd_valid <= 1'b0;
      dram_wr_data   <= wr_data_hi;
      dram_wr_be     <= wr_be_hi;
    end else begin
      // Heading to (or staying in) IDLE: data is left as-is, strobes cleared.
      dram_cmd_valid <= 1'b0;
      dram_wr_be     <= '0;
    end
  end

  // ------------------------------------------------------ read reassembly
  always_ff @(posedge dram_clk) begin
    if (dram_rst) begin
      rd_toggle    <= 1'b0;
      rd_low       <= '0;
      usr_rd_data  <= '0;
      usr_rd_valid <= 1'b0;
      rd_err       <= 1'b0;
    end else begin
      usr_rd_valid <= 1'b0;
      if (dram_rd_valid) begin
        if (rd_toggle) begin
          usr_rd_data  <= {dram_rd_data, rd_low};
          usr_rd_valid <= 1'b1;
          rd_toggle    <= 1'b0;
        end else if (rd_outstanding == 8'd0) begin
          // Stray beat: nothing asked for it, so drop it and flag.
          rd_err <= 1'b1;
        end else begin
          rd_low    <= dram_rd_data;
          rd_toggle <= 1'b1;
        end
      end
    end
  end

  // A read stays outstanding until its reassembled response is presented.
  assign rd_inc = accept && usr_cmd_rnw;
  assign rd_dec = usr_rd_valid;

  always_ff @(posedge dram_clk) begin
    if (dram_rst) begin
      rd_outstanding <= 8'd0;
    end else begin
      case ({rd_inc, rd_dec})
        2'b10:   rd_outstanding <= rd_outstanding + 8'd1;
        2'b01:   rd_outstanding <= rd_outstanding - 8'd1;
        default: rd_outstanding <= rd_outstanding;
      endcase
    end
  end

  // ------------------------------------------------------ statistics
`ifdef DRAM_BURST_ADAPTER_STATS_EN
  // Counted in the command cycle, where dram_cmd_rnw belongs to this burst.
  always_ff @(posedge dram_clk) begin
    if (dram_rst) begin
      stat_wr_cnt <= '0;
      stat_rd_cnt <= '0;
    end else if (state == BEAT0) begin
      if (dram_cmd_rnw) begin
        stat_rd_cnt <= stat_rd_cnt + 32'd1;
      end else begin
        stat_wr_cnt <= stat_wr_cnt + 32'd1;
      end
    end
  end
`else
  assign stat_wr_cnt = '0;
  assign stat_rd_cnt = '0;
`endif

endmodule
